sequenciador_menu: RTL

- Menu controller that walks the player through configuration before a game starts: mode, BPM, key (tom) and song.
- Consumes single-cycle arrow/enter pulses from the keypad interface.
- Drives menu_sel and a cursor index to the display/Arduino path.
- Holds the one-hot configuration registers that the datapath reads (modos, bpm, tom, musica).
- Sits beside the main control unit. The control unit starts it with iniciar_menu and waits for config_pronta.

---
 rtl/sequenciador_menu_if.sv | 33 +++
 rtl/sequenciador_menu.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sequenciador_menu_if.sv
// Keypad-pulse / menu-output bundle between the control path and sequenciador_menu.
// Inputs are single-cycle pulses sampled on the rising clock edge; outputs are held until the next change.
interface sequenciador_menu_if #(
    parameter int MODO   = 6,
    parameter int BPM    = 2,
    parameter int TOM    = 4,
    parameter int MUSICA = 16
) ();
    logic              iniciar_menu;
    logic              right_arrow_pressed;
    logic              left_arrow_pressed;
    logic              enter_pressed;
    logic              voltar;
    logic [2:0]        menu_sel;
    logic [3:0]        cursor;
    logic              mostra_menu;
    logic [MODO-1:0]   modos;
    logic [BPM-1:0]    bpm;
    logic [TOM-1:0]    tom;
    logic [MUSICA-1:0] musica;
    logic              config_pronta;
    logic [2:0]        state_dbg;

    modport master (
        output iniciar_menu, right_arrow_pressed, left_arrow_pressed, enter_pressed, voltar,
        input  menu_sel, cursor, mostra_menu, modos, bpm, tom, musica, config_pronta, state_dbg
    );

    modport slave (
        input  iniciar_menu, right_arrow_pressed, left_arrow_pressed, enter_pressed, voltar,
        output menu_sel, cursor, mostra_menu, modos, bpm, tom, musica, config_pronta, state_dbg
    );
endinterface

// File: rtl/sequenciador_menu.sv
// Pre-game menu sequencer: mode -> BPM -> key -> song, holding each choice as a one-hot register.
module sequenciador_menu #(
    parameter int MODO       = 6,
    parameter int BPM        = 2,
    parameter int TOM        = 4,
    parameter int MUSICA     = 16,
    parameter int MODO_GRAVA = 5
) (
    input logic              clock,
    input logic              reset,
    sequenciador_menu_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MODO   = 3'd1;
    localparam logic [2:0] S_BPM    = 3'd2;
    localparam logic [2:0] S_TOM    = 3'd3;
    localparam logic [2:0] S_MUSICA = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state;
    logic [3:0]        cursor_q;
    logic [MODO-1:0]   modos_q;
    logic [BPM-1:0]    bpm_q;
    logic [TOM-1:0]    tom_q;
    logic [MUSICA-1:0] musica_q;
    logic              pronta_q;

    // Lowest set bit wins, so a register is always mapped to a valid cursor.
    function automatic logic [3:0] first_one(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    logic [3:0] idx_modos, idx_bpm, idx_tom, idx_musica;
    assign idx_modos  = first_one(16'(modos_q));
    assign idx_bpm    = first_one(16'(bpm_q));
    assign idx_tom    = first_one(16'(tom_q));
    assign idx_musica = first_one(16'(musica_q));

    logic [3:0] lim_m1;
    logic [3:0] cursor_step;
    logic       move_r, move_l;

    assign move_r = bus.right_arrow_pressed & ~bus.left_arrow_pressed;
    assign move_l = bus.left_arrow_pressed & ~bus.right_arrow_pressed;

    always_comb begin
        lim_m1 = '0;
        case (state)
            S_MODO:   lim_m1 = 4'(MODO - 1);
            S_BPM:    lim_m1 = 4'(BPM - 1);
            S_TOM:    lim_m1 = 4'(TOM - 1);
            S_MUSICA: lim_m1 = 4'(MUSICA - 1);
            default:  lim_m1 = '0;
        endcase
    end

    always_comb begin
        cursor_step = cursor_q;
        if (move_r)      cursor_step = (cursor_q == lim_m1) ? 4'd0 : cursor_q + 4'd1;
        else if (move_l) cursor_step = (cursor_q == 4'd0) ? lim_m1 : cursor_q - 4'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= S_IDLE;
            cursor_q <= '0;
            modos_q  <= MODO'(1);
            bpm_q    <= BPM'(1);
            tom_q    <= TOM'(1);
            musica_q <= MUSICA'(1);
            pronta_q <= 1'b0;
        end else begin
            pronta_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.iniciar_menu) begin
                        state    <= S_MODO;
                        cursor_q <= idx_modos;
                    end
                end
                S_MODO: begin
                    if (bus.enter_pressed) begin
                        if (int'(cursor_q) < MODO)
                            for (int i = 0; i < MODO; i++) modos_q[i] <= (int'(cursor_q) == i);
                        state    <= S_BPM;
                        cursor_q <= idx_bpm;
                    end else if (bus.voltar) begin
                        state    <= S_IDLE;
                        cursor_q <= '0;
                    end else begin
                        cursor_q <= cursor_step;
                    end
                end
                S_BPM: begin
                    if (bus.enter_pressed) begin
                        if (int'(cursor_q) < BPM)
                            for (int i = 0; i < BPM; i++) bpm_q[i] <= (int'(cursor_q) == i);
                        state    <= S_TOM;
                        cursor_q <= idx_tom;
                    end else if (bus.voltar) begin
                        state    <= S_MODO;
                        cursor_q <= idx_modos;
                    end else begin
                        cursor_q <= cursor_step;
                    end
                end
                S_TOM: begin
                    if (bus.enter_pressed) begin
                        if (int'(cursor_q) < TOM)
                            for (int i = 0; i < TOM; i++) tom_q[i] <= (int'(cursor_q) == i);
                        // Recording mode creates a new song, so there is nothing to pick.
                        if (modos_q[MODO_GRAVA]) begin
                            state    <= S_DONE;
                            pronta_q <= 1'b1;
                            cursor_q <= '0;
                        end else begin
                            state    <= S_MUSICA;
                            cursor_q <= idx_musica;
                        end
                    end else if (bus.voltar) begin
                        state    <= S_BPM;
                        cursor_q <= idx_bpm;
                    end else begin
                        cursor_q <= cursor_step;
                    end
                end
                S_MUSICA: begin
                    if (bus.enter_pressed) begin
                        if (int'(cursor_q) < MUSICA)
                            for (int i = 0; i < MUSICA; i++) musica_q[i] <= (int'(cursor_q) == i);
                        state    <= S_DONE;
                        pronta_q <= 1'b1;
                        cursor_q <= '0;
                    end else if (bus.voltar) begin
                        state    <= S_TOM;
                        cursor_q <= idx_tom;
                    end else begin
                        cursor_q <= cursor_step;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    cursor_q <= '0;
                end
            endcase
        end
    end

    assign bus.menu_sel      = state;
    assign bus.state_dbg     = state;
    assign bus.mostra_menu   = (state == S_MODO) || (state == S_BPM) ||
                               (state == S_TOM) || (state == S_MUSICA);
    assign bus.cursor        = cursor_q;
    assign bus.modos         = modos_q;
    assign bus.bpm           = bpm_q;
    assign bus.tom           = tom_q;
    assign bus.musica        = musica_q;
    assign bus.config_pronta = pronta_q;
endmodule
